ysyx_25040111_csr_ctrl: RTL
===========================

# ysyx_25040111_csr_ctrl

Multi-cycle sequencer for CSR instructions and traps. It sits between the EXU and a single-port machine-mode CSR storage array. It accepts one system operation at a time (CSRRW, CSRRS, ECALL, MRET), performs the required read/write sequence one CSR access per cycle, and returns the old CSR value or the redirect PC. It owns all CSR state, so no other block reads or writes CSRs directly.

## Interface
- `XLEN`, 32, data/PC width
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  controller idle, can accept
- `in_op`  in  3  1=CSRRW, 2=CSRRS, 3=ECALL, 4=MRET; others rejected as illegal
- `in_csr`  in  12  CSR address (CSRRW/CSRRS only)
- `in_wdata`  in  XLEN  rs1 value (CSRRW/CSRRS)
- `in_pc`  in  XLEN  PC of the instruction (ECALL)
- `out_valid`  out  1  response present
- `out_ready`  in  1  consumer takes response
- `out_rdata`  out  XLEN  old CSR value (to rd)
- `out_redirect`  out  1  `out_npc` must be taken (ECALL/MRET)
- `out_npc`  out  XLEN  redirect target
- `out_illegal`  out  1  unsupported op or CSR address

## Operation
- Supported CSRs: mstatus 0x300 (reset 0x0000_1800), mtvec 0x305, mepc 0x341, mcause 0x342 (each resets to 0). Any other address is illegal.
- States: IDLE, RD, WR, EPC, CAUSE, VEC, RESP.
- IDLE: `in_ready`=1. On `in_valid`, latch op/csr/wdata/pc, then:
  - CSRRW/CSRRS with a legal CSR → RD
  - ECALL → EPC
  - MRET → RD (address forced to mepc)
  - otherwise → RESP with illegal=1
- RD: read the CSR and latch it as old.
  - CSRRW → WR.
  - CSRRS → WR if wdata≠0, else RESP.
  - MRET → RESP, npc=old, redirect=1.
- WR: write wdata (CSRRW) or old|wdata (CSRRS), then → RESP; rdata=old.
- EPC: write mepc=pc, then → CAUSE.
- CAUSE: write mcause=11, then → VEC.
- VEC: read mtvec; npc={mtvec[31:2],2'b00}, redirect=1, then → RESP.
- RESP: `out_valid`=1, all outputs held stable. On `out_ready` → IDLE.
- Illegal responses: rdata=0, redirect=0, no CSR write.
- Exactly one CSR-array access per cycle; no access in IDLE or RESP.

## Timing
- Reset, asynchronous: state=IDLE; `out_valid`, `out_redirect`, `out_illegal`=0; `out_rdata`, `out_npc`=0; all CSRs take their reset values. Reset in mid-sequence abandons the operation, and CSR writes already done by then are lost to reset.
- Acceptance at edge 0; `out_valid` rises after:
  - CSRRW: 3 cycles
  - CSRRS: 3 cycles (2 if wdata=0)
  - ECALL: 4 cycles
  - MRET: 2 cycles
  - illegal: 1 cycle
- The CSR write takes effect at the edge leaving WR/EPC/CAUSE. A read in RD/VEC sees all earlier writes.
- `in_ready` is 0 from acceptance until the cycle after the RESP handshake, so back-to-back throughput is one op per latency+1 cycles. No bypass from RESP to a new accept.
- `out_valid` with `out_ready` held low: the controller stays in RESP indefinitely and its outputs do not change.

## Structure
- Add `CSR_MSTATUS`, `CSR_MCAUSE` and the `CSROP_*` op encodings to `ysyx_25040111_inc.vh`, next to the existing `MEPC`/`MTVEC` defines.
- Sub-module `ysyx_25040111_csr_file`: 4-entry storage with address decode, combinational read, synchronous write, a legal-address flag, and per-entry reset values.
- The controller holds the FSM plus the latched request, old-value, npc and flag registers.

## Test plan
- Reset, then CSRRS mstatus with wdata=0 → response 2 cycles after accept; rdata=0x1800; no write.
- CSRRW mtvec wdata=0x8000_0103 → rdata=0 after 3 cycles. A following CSRRS mtvec wdata=0 → rdata=0x8000_0103.
- ECALL pc=0x8000_0040 with mtvec=0x8000_0103 → after 4 cycles redirect=1, npc=0x8000_0100. CSRRS reads then return mepc=0x8000_0040 and mcause=11.
- MRET after that ECALL → 2 cycles; redirect=1, npc=0x8000_0040.
- CSRRW csr=0x7C0 → 1 cycle; illegal=1, rdata=0; all CSRs unchanged. op=7 behaves the same.
- Hold out_ready=0 for 5 cycles in RESP → outputs stable and in_ready=0. Then assert reset during the EPC cycle of an ECALL → IDLE, mepc=0, out_valid=0.

Source files
------------

// File: rtl/ysyx_25040111_csr_ctrl_pkg.sv
// Shared definitions for the CSR sequencer: CSR addresses, op encodings,
// reset values and the controller state type.
// Imported by ysyx_25040111_csr_file and ysyx_25040111_csr_ctrl.
package ysyx_25040111_csr_ctrl_pkg;

  localparam int XLEN = 32;

  // Machine-mode CSR addresses held by the storage array
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // System op encodings on in_op; every other value is illegal
  localparam logic [2:0] CSROP_CSRRW = 3'd1;
  localparam logic [2:0] CSROP_CSRRS = 3'd2;
  localparam logic [2:0] CSROP_ECALL = 3'd3;
  localparam logic [2:0] CSROP_MRET  = 3'd4;

  localparam logic [XLEN-1:0] MSTATUS_RST  = 32'h0000_1800;
  localparam logic [XLEN-1:0] MCAUSE_ECALL = 32'd11;  // environment call from M-mode

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_EPC,
    S_CAUSE,
    S_VEC,
    S_RESP
  } csr_state_t;

endpackage

// File: rtl/ysyx_25040111_csr_file.sv
// 4-entry machine-mode CSR storage: combinational read, synchronous write.
// Latency: read same cycle, write visible after the next clock edge.
// Backpressure: none; a single port driven by the controller.
// Ports: clock/reset, addr (12b), we + wdata, rdata, legal (addr is implemented).
module ysyx_25040111_csr_file
  import ysyx_25040111_csr_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [11:0]     addr,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            legal
);

  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;

  always_comb begin
    rdata = '0;
    legal = 1'b1;
    case (addr)
      CSR_MSTATUS: rdata = mstatus;
      CSR_MTVEC:   rdata = mtvec;
      CSR_MEPC:    rdata = mepc;
      CSR_MCAUSE:  rdata = mcause;
      default:     legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus <= MSTATUS_RST;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else if (we) begin
      case (addr)
        CSR_MSTATUS: mstatus <= wdata;
        CSR_MTVEC:   mtvec   <= wdata;
        CSR_MEPC:    mepc    <= wdata;
        CSR_MCAUSE:  mcause  <= wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_25040111_csr_ctrl.sv
// Multi-cycle sequencer for CSRRW/CSRRS/ECALL/MRET; sole owner of CSR state.
// Latency accept->out_valid: CSRRW 3, CSRRS 3 (2 if wdata=0), ECALL 4, MRET 2, illegal 1.
// Backpressure: in_ready only in IDLE; response held in RESP until out_ready.
// Ports: in_valid/in_ready/in_op/in_csr/in_wdata/in_pc request side;
//        out_valid/out_ready/out_rdata/out_redirect/out_npc/out_illegal response side.
module ysyx_25040111_csr_ctrl
  import ysyx_25040111_csr_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [11:0]     in_csr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_npc,
  output logic            out_illegal
);

  csr_state_t state, state_nxt;

  logic [2:0]      op_q;
  logic [11:0]     csr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] npc_q;
  logic            redirect_q;
  logic            illegal_q;

  logic [11:0]     csr_addr;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_legal;

  logic accept;
  assign accept = (state == S_IDLE) && in_valid;

  ysyx_25040111_csr_file u_csr_file (
    .clock (clock),
    .reset (reset),
    .addr  (csr_addr),
    .we    (csr_we),
    .wdata (csr_wdata),
    .rdata (csr_rdata),
    .legal (csr_legal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          case (in_op)
            CSROP_CSRRW, CSROP_CSRRS: state_nxt = csr_legal ? S_RD : S_RESP;
            CSROP_ECALL:              state_nxt = S_EPC;
            CSROP_MRET:               state_nxt = S_RD;
            default:                  state_nxt = S_RESP;
          endcase
        end
      end
      S_RD: begin
        if (op_q == CSROP_CSRRW)                          state_nxt = S_WR;
        else if (op_q == CSROP_CSRRS && wdata_q != '0)    state_nxt = S_WR;
        else                                              state_nxt = S_RESP;
      end
      S_WR:    state_nxt = S_RESP;
      S_EPC:   state_nxt = S_CAUSE;
      S_CAUSE: state_nxt = S_VEC;
      S_VEC:   state_nxt = S_RESP;
      S_RESP:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One storage-array access per state. In IDLE the port only carries in_csr
  // for the legality decode; nothing is written and the read data is dropped.
  always_comb begin
    csr_addr  = csr_q;
    csr_we    = 1'b0;
    csr_wdata = wdata_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        csr_addr = in_csr;
        in_ready = 1'b1;
      end
      S_RD: csr_addr = csr_q;
      S_WR: begin
        csr_addr  = csr_q;
        csr_we    = 1'b1;
        csr_wdata = (op_q == CSROP_CSRRS) ? (old_q | wdata_q) : wdata_q;
      end
      S_EPC: begin
        csr_addr  = CSR_MEPC;
        csr_we    = 1'b1;
        csr_wdata = pc_q;
      end
      S_CAUSE: begin
        csr_addr  = CSR_MCAUSE;
        csr_we    = 1'b1;
        csr_wdata = MCAUSE_ECALL;
      end
      S_VEC:  csr_addr  = CSR_MTVEC;
      S_RESP: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      csr_q      <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      old_q      <= '0;
      npc_q      <= '0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q       <= in_op;
            csr_q      <= (in_op == CSROP_MRET) ? CSR_MEPC : in_csr;
            wdata_q    <= in_wdata;
            pc_q       <= in_pc;
            old_q      <= '0;
            npc_q      <= '0;
            redirect_q <= 1'b0;
            // Only rejected requests go straight from IDLE to RESP
            illegal_q  <= (state_nxt == S_RESP);
          end
        end
        S_RD: begin
          old_q <= csr_rdata;
          if (op_q == CSROP_MRET) begin
            npc_q      <= csr_rdata;
            redirect_q <= 1'b1;
          end
        end
        S_VEC: begin
          npc_q      <= {csr_rdata[XLEN-1:2], 2'b00};
          redirect_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_rdata    = old_q;
  assign out_npc      = npc_q;
  assign out_redirect = redirect_q;
  assign out_illegal  = illegal_q;

endmodule
